// File: rtl/mm_pkg.sv
// Shared constants and flat-vector index helpers for the 4x4 matrix multiplier.
// Element indices are row-major; callers scale by the element width.
package mm_pkg;

    localparam int N = 4;

    function automatic int elem_a(input int r, input int c);
        return r * N + c;
    endfunction

    function automatic int elem_c(input int r, input int c);
        return r * N + c;
    endfunction

endpackage

// File: rtl/matrix_multiplier_4x4_dot4.sv
// Combinational 4-term unsigned dot product, accumulated at 2*DATA_W+2 bits
// and truncated (mod 2^OUT_W) to the output width.
module dot4
    import mm_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic [N-1:0][DATA_W-1:0] a_vec,
    input  logic [N-1:0][DATA_W-1:0] b_vec,
    output logic [OUT_W-1:0]         dot
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + 2;
    localparam int WIDE_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    logic [N-1:0][PROD_W-1:0] prod;
    logic [ACC_W-1:0]         acc;
    logic [WIDE_W-1:0]        acc_wide;

    always_comb begin
        prod     = '0;
        acc      = '0;
        acc_wide = '0;
        for (int k = 0; k < N; k++) begin
            prod[k] = {{DATA_W{1'b0}}, a_vec[k]} * {{DATA_W{1'b0}}, b_vec[k]};
            acc     = acc + ACC_W'(prod[k]);
        end
        // Widening first lets OUT_W exceed the accumulator without a part-select overrun.
        acc_wide = WIDE_W'(acc);
        dot      = acc_wide[OUT_W-1:0];
    end

endmodule

// File: rtl/matrix_multiplier_4x4.sv
// 4x4 unsigned matrix multiply C = A x B: sixteen parallel dot4 leaves feeding
// one output register bank, one result per accepted input, 1-cycle latency.
module matrix_multiplier_4x4
    import mm_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [N*N*DATA_W-1:0]   a_flat,
    input  logic [N*N*DATA_W-1:0]   b_flat,
    output logic                    out_valid,
    output logic [N*N*OUT_W-1:0]    c_flat
);

    // Handshake: operands are taken on any rising edge with in_valid=1; the product is
    // presented with out_valid=1 for exactly the next cycle. There is no ready, so the
    // consumer must take it then; with in_valid=0 out_valid drops and c_flat keeps its value.

    logic [N*N-1:0][OUT_W-1:0] c_next;
    logic [N*N-1:0][OUT_W-1:0] c_d, c_q;
    logic                      valid_d, valid_q;

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [N-1:0][DATA_W-1:0] a_row;
            logic [N-1:0][DATA_W-1:0] b_col;

            for (genvar k = 0; k < N; k++) begin : g_k
                localparam int AI = elem_a(r, k);
                localparam int BI = elem_a(k, c);
                assign a_row[k] = a_flat[AI*DATA_W +: DATA_W];
                assign b_col[k] = b_flat[BI*DATA_W +: DATA_W];
            end

            dot4 #(
                .DATA_W (DATA_W),
                .OUT_W  (OUT_W)
            ) u_dot4 (
                .a_vec (a_row),
                .b_vec (b_col),
                .dot   (c_next[elem_c(r, c)])
            );
        end
    end

    always_comb begin
        valid_d = in_valid;
        c_d     = c_q;
        if (in_valid) begin
            c_d = c_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            c_q     <= '0;
        end else begin
            valid_q <= valid_d;
            c_q     <= c_d;
        end
    end

    assign out_valid = valid_q;
    assign c_flat    = c_q;

endmodule

// File: tb/tb_matrix_multiplier_4x4.sv
// Scoreboard bench for matrix_multiplier_4x4: expected matrices queued at drive time,
// popped and compared on each out_valid; out_valid and hold behaviour checked every cycle.
module tb_matrix_multiplier_4x4;

    localparam int DATA_W = 8;
    localparam int OUT_W  = 16;
    localparam int AW     = 16 * DATA_W;
    localparam int CW     = 16 * OUT_W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [AW-1:0] a_flat;
    logic [AW-1:0] b_flat;
    logic          out_valid;
    logic [CW-1:0] c_flat;

    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] last_exp;
    logic          exp_valid;
    int            n_cmp;
    int            n_err;

    matrix_multiplier_4x4 #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .out_valid (out_valid),
        .c_flat    (c_flat)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) exp_valid <= 1'b0;
        else     exp_valid <= in_valid;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] model(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [CW-1:0] res;
        int unsigned   sum;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sum = 0;
                for (int k = 0; k < 4; k++) begin
                    sum += a[(r*4+k)*DATA_W +: DATA_W] * b[(k*4+c)*DATA_W +: DATA_W];
                end
                res[(r*4+c)*OUT_W +: OUT_W] = sum[OUT_W-1:0];
            end
        end
        return res;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("rst_valid", CW'(out_valid), CW'(0));
            check("rst_c", c_flat, '0);
            last_exp = '0;
        end else begin
            check("out_valid", CW'(out_valid), CW'(exp_valid));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", CW'(out_valid), CW'(0));
                end else begin
                    last_exp = exp_q.pop_front();
                    check("result", c_flat, last_exp);
                end
            end else begin
                check("hold", c_flat, last_exp);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [CW-1:0] exp);
        @(negedge clk);
        a_flat   = a;
        b_flat   = b;
        in_valid = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a_flat   = {4{$urandom}};
            b_flat   = {4{$urandom}};
        end
    endtask

    function automatic logic [AW-1:0] rand_mat();
        logic [AW-1:0] m;
        for (int i = 0; i < 16; i++) m[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
        return m;
    endfunction

    // ---------------- stimulus ----------------
    logic [AW-1:0] mat_seq;
    logic [AW-1:0] mat_id;
    logic [AW-1:0] mat_ff;
    logic [CW-1:0] c_seq;
    logic [CW-1:0] c_sq;
    logic [CW-1:0] c_ovf;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    int            sq_vals[16] = '{90, 100, 110, 120, 202, 228, 254, 280,
                                   314, 356, 398, 440, 426, 484, 542, 600};

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        last_exp = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a_flat   = '0;
        b_flat   = '0;

        for (int i = 0; i < 16; i++) begin
            mat_seq[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
            mat_id[i*DATA_W +: DATA_W]  = (i / 4 == i % 4) ? DATA_W'(1) : DATA_W'(0);
            mat_ff[i*DATA_W +: DATA_W]  = DATA_W'(255);
            c_seq[i*OUT_W +: OUT_W]     = OUT_W'(i + 1);
            c_sq[i*OUT_W +: OUT_W]      = OUT_W'(sq_vals[i]);
            c_ovf[i*OUT_W +: OUT_W]     = OUT_W'(63492);
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // identity then square back to back, then idle to observe hold
        drive(mat_seq, mat_id, c_seq);
        drive(mat_seq, mat_seq, c_sq);
        idle(1);
        @(negedge clk);
        check("hold_square", c_flat, c_sq);
        check("hold_valid", CW'(out_valid), CW'(0));

        // overflow wrap and zero operand
        drive(mat_ff, mat_ff, c_ovf);
        drive('0, rand_mat(), '0);
        idle(2);

        // random streaming with random gaps
        for (int t = 0; t < 24; t++) begin
            ra = rand_mat();
            rb = rand_mat();
            drive(ra, rb, model(ra, rb));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // async reset mid-stream with in_valid held high
        drive(mat_seq, mat_seq, c_sq);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_now_valid", CW'(out_valid), CW'(0));
        check("rst_now_c", c_flat, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_flat   = rand_mat();
            b_flat   = rand_mat();
        end
        @(negedge clk);
        ra       = rand_mat();
        rb       = rand_mat();
        a_flat   = ra;
        b_flat   = rb;
        in_valid = 1'b1;
        rst      = 1'b0;
        exp_q.push_back(model(ra, rb));
        idle(3);

        check("drain", CW'(exp_q.size()), CW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
